onchip_mem_arbiter: RTL and testbench



---
 rtl/onchip_mem_arbiter_pkg.sv | 22 ++
 rtl/onchip_mem_rd_tag_pipe.sv | 36 +++
 rtl/onchip_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared constants for the on-chip RAM arbiter: port indices, FSM states, default widths.
// No logic of its own; imported by the arbiter top and the read-tag pipeline.
// Widths here are defaults only; instances may override them through parameters.
package onchip_mem_arbiter_pkg;

   // Port indices, also used as the read-return tag
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_VID = 1'b1;

   // Default widths
   localparam int DEF_ADDR_W     = 15;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_BURST_W    = 8;
   localparam int DEF_RD_LATENCY = 1;

   // Arbiter states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

endpackage

// File: rtl/onchip_mem_rd_tag_pipe.sv
// Valid/port-tag delay line matching the RAM read latency.
// Latency: RD_LATENCY cycles from i_vld to o_vld.
// No backpressure: one entry per cycle enters and leaves; reset flushes all entries.
module onchip_mem_rd_tag_pipe #(
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_vld,
   input  logic i_tag,
   output logic o_vld,
   output logic o_tag
);

   logic [RD_LATENCY-1:0] r_vld;
   logic [RD_LATENCY-1:0] r_tag;

   // Shift issued-read valid and tag along with the RAM pipeline; reset drops in-flight reads
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= '0;
         r_tag <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_tag[0] <= i_tag;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign o_vld = r_vld[RD_LATENCY-1];
   assign o_tag = r_tag[RD_LATENCY-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between a CPU master (port 0) and a burst video reader (port 1).
// Latency: RAM driven combinationally in the grant cycle; readdatavalid RD_LATENCY cycles after issue.
// Backpressure: losing / non-owning master sees waitrequest; a video burst holds the RAM until its last word.
module onchip_mem_arbiter
   import onchip_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BURST_W    = DEF_BURST_W,
   parameter int RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic                  clk,
   input  logic                  reset,
   // CPU data master
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   // Video frame reader
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [BURST_W-1:0]    m1_burstcount,
   input  logic                  m1_read,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   // RAM
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   input  logic [DATA_W-1:0]     mem_readdata,
   output logic                  mem_clken
);

   localparam int BE_W = DATA_W / 8;

   state_t               r_state;
   logic                 r_last_grant;
   logic [ADDR_W-1:0]    r_addr;
   logic [BURST_W-1:0]   r_cnt;

   logic                 w_req0;
   logic                 w_req1;
   logic                 w_idle;
   logic                 w_grant0;
   logic                 w_grant1;
   logic                 w_burst_issue;
   logic [BURST_W-1:0]   w_len;
   logic                 w_rd_vld;
   logic                 w_rd_tag;
   logic                 w_pipe_vld;
   logic                 w_pipe_tag;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read;

   // Reset blocks any new issue immediately, including the remainder of an active burst
   assign w_idle        = (r_state == ST_IDLE)  & ~reset;
   assign w_burst_issue = (r_state == ST_BURST) & ~reset;

   // On contention the port that did not win last time gets the RAM
   assign w_grant0 = w_idle & w_req0 & (~w_req1 | (r_last_grant == PORT_VID));
   assign w_grant1 = w_idle & w_req1 & (~w_req0 | (r_last_grant == PORT_CPU));

   // A zero burstcount is handled as a single word
   assign w_len = (m1_burstcount == '0) ? BURST_W'(1) : m1_burstcount;

   assign m0_waitrequest = w_req0 & ~w_grant0;
   assign m1_waitrequest = w_req1 & ~w_grant1;

   // RAM pins: burst engine has priority, then a fresh video grant, else the CPU
   assign mem_address    = w_burst_issue ? r_addr :
                           w_grant1      ? m1_address : m0_address;
   assign mem_byteenable = w_grant0 ? m0_byteenable : {BE_W{1'b1}};
   assign mem_chipselect = w_grant0 | w_grant1 | w_burst_issue;
   assign mem_write      = w_grant0 & m0_write;
   assign mem_writedata  = m0_writedata;
   assign mem_clken      = 1'b1;

   // A simultaneous read+write from the CPU is a write and returns no data
   assign w_rd_vld = (w_grant0 & m0_read & ~m0_write) | w_grant1 | w_burst_issue;
   assign w_rd_tag = (w_grant1 | w_burst_issue) ? PORT_VID : PORT_CPU;

   // Arbitration state, burst address and remaining-word counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= PORT_VID;
         r_addr       <= '0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant0) begin
                  r_last_grant <= PORT_CPU;
               end else if (w_grant1) begin
                  r_last_grant <= PORT_VID;
                  r_addr       <= m1_address + ADDR_W'(1);
                  r_cnt        <= w_len - BURST_W'(1);
                  if (w_len > BURST_W'(1)) begin
                     r_state <= ST_BURST;
                  end
               end
            end
            ST_BURST: begin
               r_addr <= r_addr + ADDR_W'(1);
               r_cnt  <= r_cnt - BURST_W'(1);
               if (r_cnt == BURST_W'(1)) begin
                  r_state      <= ST_IDLE;
                  r_last_grant <= PORT_VID;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   onchip_mem_rd_tag_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .i_vld (w_rd_vld),
      .i_tag (w_rd_tag),
      .o_vld (w_pipe_vld),
      .o_tag (w_pipe_tag)
   );

   // Both masters see the RAM data; only the owner of the returning read gets valid
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = w_pipe_vld & (w_pipe_tag == PORT_CPU) & ~reset;
   assign m1_readdatavalid = w_pipe_vld & (w_pipe_tag == PORT_VID) & ~reset;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle RAM.
// Expected read returns are queued at issue time and matched by an independent monitor.
// Pin-level RAM address/strobe checks are made inline by the stimulus.
module tb_onchip_mem_arbiter;

   logic        clk;
   logic        reset;
   logic [14:0] m0_address;
   logic [3:0]  m0_byteenable;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;
   logic [14:0] m1_address;
   logic [7:0]  m1_burstcount;
   logic        m1_read;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;
   logic [14:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_clken;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] ram [0:32767];

   onchip_mem_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_burstcount    (m1_burstcount),
      .m1_read          (m1_read),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_readdata     (mem_readdata),
      .mem_clken        (mem_clken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM with byte enables and 1-cycle read latency
   always @(posedge clk) begin
      if (mem_chipselect === 1'b1) begin
         if (mem_write === 1'b1) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_cmp(input logic port, input logic [31:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL unexpected_rdvalid: port %0d data 0x%08h, expected no return at %0t",
                  port, data, $time);
      end else begin
         e = exp_q.pop_front();
         check("rd_port", {31'd0, port}, {31'd0, e.port});
         check("rd_data", data, e.data);
      end
   endtask

   // Monitor: every readdatavalid must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (m0_readdatavalid === 1'b1) pop_cmp(1'b0, m0_readdata);
      if (m1_readdatavalid === 1'b1) pop_cmp(1'b1, m1_readdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic port, input logic [31:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      exp_q.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) ram[i] = i;
      mem_readdata  = '0;
      reset         = 1'b1;
      m0_address    = '0;
      m0_byteenable = '0;
      m0_read       = 1'b0;
      m0_write      = 1'b0;
      m0_writedata  = '0;
      m1_address    = '0;
      m1_burstcount = '0;
      m1_read       = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rst_chipselect", {31'd0, mem_chipselect}, 32'd0);
      check("rst_mem_write", {31'd0, mem_write}, 32'd0);
      check("rst_rdvalid", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      check("clken", {31'd0, mem_clken}, 32'd1);

      // CPU full-word write then read
      tick(); reset = 1'b0;
      tick();
      m0_write = 1'b1; m0_address = 15'h0010; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
      @(negedge clk);
      check("wr_wait", {31'd0, m0_waitrequest}, 32'd0);
      check("wr_strobe", {30'd0, mem_chipselect, mem_write}, 32'd3);
      tick();
      m0_write = 1'b0; m0_read = 1'b1;
      push(1'b0, 32'hDEADBEEF);
      @(negedge clk);
      check("rd_wait", {31'd0, m0_waitrequest}, 32'd0);
      check("rd_strobe", {30'd0, mem_chipselect, mem_write}, 32'd2);
      tick();
      m0_read = 1'b0;
      @(negedge clk);
      check("rd_lat1", {31'd0, m0_readdatavalid}, 32'd1);

      // Partial byte-lane write over all-ones
      tick();
      m0_write = 1'b1; m0_address = 15'h0020; m0_byteenable = 4'hF; m0_writedata = 32'hFFFFFFFF;
      tick();
      m0_byteenable = 4'h3; m0_writedata = 32'h11223344;
      tick();
      m0_write = 1'b0; m0_read = 1'b1;
      push(1'b0, 32'hFFFF3344);
      tick();
      m0_read = 1'b0;

      // Video burst of 4 from 0x0100
      tick();
      m1_read = 1'b1; m1_address = 15'h0100; m1_burstcount = 8'd4;
      @(negedge clk);
      check("b4_wait", {31'd0, m1_waitrequest}, 32'd0);
      check("b4_addr0", {17'd0, mem_address}, 32'h100);
      for (int k = 0; k < 4; k++) push(1'b1, 32'h100 + k);
      for (int k = 1; k < 4; k++) begin
         tick();
         m1_read = 1'b0;
         @(negedge clk);
         check("b4_addr", {17'd0, mem_address}, 32'h100 + k);
         check("b4_cs_be", {27'd0, mem_chipselect, mem_byteenable}, 32'h1F);
         check("b4_rdvalid", {31'd0, m1_readdatavalid}, 32'd1);
      end
      tick();
      @(negedge clk);
      check("b4_done_cs", {31'd0, mem_chipselect}, 32'd0);
      check("b4_last_valid", {31'd0, m1_readdatavalid}, 32'd1);

      // Contention right after reset: CPU first, then burst of 3, CPU held off
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      tick();
      m0_read = 1'b1; m0_address = 15'h0200;
      m1_read = 1'b1; m1_address = 15'h0300; m1_burstcount = 8'd3;
      @(negedge clk);
      check("ct_w0", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
      check("ct_addr0", {17'd0, mem_address}, 32'h200);
      push(1'b0, 32'h200);
      tick();
      m0_address = 15'h0210;
      @(negedge clk);
      check("ct_w1", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
      check("ct_addr1", {17'd0, mem_address}, 32'h300);
      for (int k = 0; k < 3; k++) push(1'b1, 32'h300 + k);
      tick();
      m1_read = 1'b0;
      @(negedge clk);
      check("ct_w2", {31'd0, m0_waitrequest}, 32'd1);
      check("ct_addr2", {17'd0, mem_address}, 32'h301);
      tick();
      @(negedge clk);
      check("ct_w3", {31'd0, m0_waitrequest}, 32'd1);
      check("ct_addr3", {17'd0, mem_address}, 32'h302);
      tick();
      @(negedge clk);
      check("ct_w4", {31'd0, m0_waitrequest}, 32'd0);
      check("ct_addr4", {17'd0, mem_address}, 32'h210);
      push(1'b0, 32'h210);
      tick();
      m0_read = 1'b0;

      // Burst of 2 wrapping at the top of the address space
      tick();
      m1_read = 1'b1; m1_address = 15'h7FFF; m1_burstcount = 8'd2;
      @(negedge clk);
      check("wrap_addr0", {17'd0, mem_address}, 32'h7FFF);
      push(1'b1, 32'h7FFF);
      push(1'b1, 32'h0000);
      tick();
      m1_read = 1'b0;
      @(negedge clk);
      check("wrap_addr1", {17'd0, mem_address}, 32'h0000);
      tick();
      tick();

      // Reset during the second word of a burst of 8: nothing more issued or returned
      m1_read = 1'b1; m1_address = 15'h0400; m1_burstcount = 8'd8;
      @(negedge clk);
      check("ab_addr0", {17'd0, mem_address}, 32'h400);
      tick();
      m1_read = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("ab_cs", {31'd0, mem_chipselect}, 32'd0);
      check("ab_valid", {31'd0, m1_readdatavalid}, 32'd0);
      tick();
      reset = 1'b0;
      m0_read = 1'b1; m0_address = 15'h0500;
      m1_read = 1'b1; m1_address = 15'h0600; m1_burstcount = 8'd1;
      @(negedge clk);
      check("ab_after_cs", {31'd0, mem_chipselect}, 32'd1);
      check("ab_grant", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
      check("ab_after_addr", {17'd0, mem_address}, 32'h500);
      push(1'b0, 32'h500);
      tick();
      m0_read = 1'b0;
      @(negedge clk);
      check("single_grant", {31'd0, m1_waitrequest}, 32'd0);
      check("single_addr", {17'd0, mem_address}, 32'h600);
      push(1'b1, 32'h600);

      // Zero burstcount behaves as a single word
      tick();
      m1_address = 15'h0700; m1_burstcount = 8'd0;
      @(negedge clk);
      check("bc0_addr", {17'd0, mem_address}, 32'h700);
      push(1'b1, 32'h700);
      tick();
      m1_read = 1'b0;
      @(negedge clk);
      check("bc0_idle", {31'd0, mem_chipselect}, 32'd0);

      tick();
      tick();
      tick();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
